fir_controller: RTL
===================

Name: fir_controller

Overview:
- Sequencing FSM for the FIR datapath; sits directly upstream of the tap Counter and drives its `increament`/`clear`, consuming its `Co`.
- Accepts one input sample per valid/ready handshake and loads it into the sample shift buffer.
- Runs LENGTH multiply-accumulate cycles, then presents a one-cycle output_valid pulse to the downstream consumer.

Parameters:
- LENGTH, 64, number of filter taps; must match COUNT_NUM of the attached Counter; LENGTH >= 2.
- CNT_W, $clog2(LENGTH), width of the internal shadow tap count (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_valid  input  1  upstream sample available.
- cnt_co  input  1  Counter Co; high when the tap index equals LENGTH-1.
- ready  output  1  controller can accept a sample.
- in_load  output  1  capture the input sample into the datapath input register.
- shift_en  output  1  shift the captured sample into the sample buffer.
- cnt_clear  output  1  to Counter clear.
- cnt_inc  output  1  to Counter increament.
- acc_clear  output  1  zero the accumulator.
- acc_en  output  1  accumulate product of current tap.
- output_valid  output  1  accumulator holds a finished result; one-cycle pulse.
- err  output  1  sticky protocol error flag.

Behaviour:
- States: IDLE, LOAD, MAC, DONE; DRAIN only with the optional feature. State is held in a registered state variable.
- Reset (rst=0, async): state=IDLE, shadow count=0, err=0.
- Values during reset: ready=1; in_load, shift_en, cnt_clear, cnt_inc, acc_clear, acc_en and output_valid all 0.
- IDLE:
  - ready=1; in_load = input_valid (Mealy; the only combinational input-to-output path).
  - On input_valid=1, go to LOAD; otherwise stay in IDLE.
- LOAD (1 cycle):
  - shift_en=1, cnt_clear=1, acc_clear=1; shadow count cleared to 0.
  - Next state is MAC.
- MAC:
  - acc_en=1 and cnt_inc=1 every cycle; shadow count increments.
  - If cnt_co=1, this is the final MAC and the next state is DONE.
  - Otherwise stay in MAC.
- DONE (1 cycle):
  - output_valid=1.
  - Next state is IDLE.
- ready=0 in every state except IDLE. input_valid outside IDLE is ignored; the sample is not lost, because upstream holds it until ready.
- Latency:
  - Handshake at cycle 0, LOAD at cycle 1, MAC at cycles 2..LENGTH+1, output_valid at cycle LENGTH+2.
  - Back-to-back samples are accepted every LENGTH+3 cycles.
- Outputs other than ready/in_load are Moore decodes of state; outputs are mutually exclusive per state as listed.
- Consistency checking:
  - A shadow count of MAC cycles is kept, independent of the Counter.
  - If cnt_co=1 while shadow count != LENGTH-1, err is set.
  - If shadow count == LENGTH-1 and cnt_co=0, err is set; the FSM still goes to DONE, so the FSM terminates on either condition.
  - err is cleared only by reset.
- cnt_co in IDLE/LOAD/DONE: ignored, no error.
- Reset asserted mid-MAC: immediate return to IDLE and no output_valid. The Counter is resynchronised by the next LOAD's cnt_clear.

Optional Feature:
- Macro FIR_CTRL_PIPE_EN.
- When defined:
  - A DRAIN state is inserted between MAC and DONE for one cycle, covering a registered multiplier stage.
  - In DRAIN, acc_en=1 and cnt_inc=0.
  - output_valid moves to cycle LENGTH+3; the handshake period becomes LENGTH+4.
- When undefined: no DRAIN state; timing is exactly as above.

Test Plan:
- Reset: rst=0 with random inputs -> ready=1, err=0, all other outputs 0; after release with input_valid=0 for 10 cycles -> stays IDLE.
- Single sample, LENGTH=64, Counter attached:
  - input_valid at cycle 0 -> in_load=1 at cycle 0; shift_en/cnt_clear/acc_clear=1 at cycle 1.
  - acc_en=1 for exactly 64 cycles (2..65); output_valid=1 only at cycle 66; ready back to 1 at cycle 67; err=0.
- Back-to-back: input_valid held high continuously -> handshakes at cycles 0, 67, 134; exactly 3 output_valid pulses at 66, 133, 200; input_valid ignored while ready=0.
- Premature Co: force cnt_co=1 on the 10th MAC cycle -> next state DONE, output_valid one cycle later, err=1 and stays 1 after subsequent clean frames until rst.
- Mid-operation reset: rst=0 on the 20th MAC cycle -> outputs return to reset values that cycle, no output_valid; the next frame completes with correct 66-cycle latency.
- FIR_CTRL_PIPE_EN defined, LENGTH=4: handshake at cycle 0 -> acc_en=1 at cycles 2..6 (4 MAC + 1 DRAIN), cnt_inc=1 only at cycles 2..5, output_valid at cycle 7.

Source files
------------

// File: rtl/fir_controller.sv
// Sequencing FSM for the FIR datapath: sample handshake, LENGTH MAC cycles, one-cycle result pulse.
// Define FIR_CTRL_PIPE_EN to add a DRAIN cycle that covers a registered multiplier stage.
module fir_controller #(
  parameter int LENGTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic input_valid,
  input  logic cnt_co,
  output logic ready,
  output logic in_load,
  output logic shift_en,
  output logic cnt_clear,
  output logic cnt_inc,
  output logic acc_clear,
  output logic acc_en,
  output logic output_valid,
  output logic err
);

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(LENGTH - 1);

  // state  | meaning
  // IDLE   | waiting for a sample, ready=1
  // LOAD   | shift sample in, clear Counter and accumulator
  // MAC    | one tap per cycle until Co or shadow count says last
  // DRAIN  | flush the registered multiplier (pipelined build only)
  // DONE   | accumulator result valid for one cycle
`ifdef FIR_CTRL_PIPE_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             last_tap;

  assign last_tap = (cnt_q == LAST_TAP);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ready        = 1'b0;
    in_load      = 1'b0;
    shift_en     = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    output_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        // gated by rst so nothing is captured while reset is held
        in_load = input_valid & rst;
        if (input_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_en  = 1'b1;
        cnt_clear = 1'b1;
        acc_clear = 1'b1;
        cnt_d     = '0;
        state_d   = S_MAC;
      end
      S_MAC: begin
        acc_en  = 1'b1;
        cnt_inc = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Counter and shadow count must agree on the last tap
        if (cnt_co != last_tap) err_d = 1'b1;
        if (cnt_co || last_tap) begin
`ifdef FIR_CTRL_PIPE_EN
          state_d = S_DRAIN;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FIR_CTRL_PIPE_EN
      S_DRAIN: begin
        acc_en  = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        output_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
